memory_bus_controller: RTL and testbench

- Sits directly downstream of the drisc core's external pads: address_bus, data_bus_out, data_size, read and write.
- Turns each CPU access into a sized, lane-aligned transaction on a word-wide RAM port (req/ready handshake) or a single-cycle memory-mapped IO port.
- Returns read data on cpu_data_in unshifted; the core's input buffer does the lane extraction.
- Drives cpu_stall while a transaction is in flight.

---
 rtl/drisc_bus_pkg.sv | 28 ++
 rtl/store_lane_formatter.sv | 29 ++
 rtl/memory_bus_controller.sv | 135 +++++++++++++
 tb/tb_memory_bus_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drisc_bus_pkg.sv
// Shared types and lane helpers for the drisc external bus.
// Pure declarations: no latency, no backpressure.
package drisc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RAM_WAIT,
      RAM_HOLD,
      IO_ACCESS,
      DONE
   } bus_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << offset;
         SIZE_HALF: be = 4'b0011 << offset;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/store_lane_formatter.sv
// Size/offset to lane enables, lane-replicated store data and misalignment flag.
// Combinational, zero latency; no backpressure.
module store_lane_formatter
   import drisc_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] data,
   output logic [3:0]  byte_enable,
   output logic [31:0] write_data,
   output logic        misaligned
);

   always_comb begin
      byte_enable = lane_enable(size, offset);
      write_data  = data;
      misaligned  = 1'b0;
      case (size)
         SIZE_BYTE: write_data = {4{data[7:0]}};
         SIZE_HALF: begin
            write_data = {2{data[15:0]}};
            misaligned = (offset == 2'd3);
         end
         SIZE_WORD: misaligned = (offset != 2'd0);
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_bus_controller.sv
// Turns drisc core pad accesses into sized RAM (req/ready) or single-cycle IO transactions.
// Latency RAM 2+ready+WAIT_STATES, IO 2, error 1; cpu_stall holds the core until DONE.
module memory_bus_controller
   import drisc_bus_pkg::*;
#(
   parameter int          RAM_ADDR_WIDTH = 12,
   parameter logic [31:0] IO_BASE        = 32'hFFFF_0000,
   parameter int          WAIT_STATES    = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [31:0]               cpu_address,
   input  logic [31:0]               cpu_data_out,
   input  logic [1:0]                cpu_data_size,
   input  logic                      cpu_read,
   input  logic                      cpu_write,
   output logic [31:0]               cpu_data_in,
   output logic                      cpu_stall,
   output logic                      bus_error,
   output logic                      mem_request,
   output logic                      mem_write,
   output logic [RAM_ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]                mem_byte_enable,
   output logic [31:0]               mem_write_data,
   input  logic [31:0]               mem_read_data,
   input  logic                      mem_ready,
   output logic                      io_select,
   output logic                      io_write,
   output logic [15:0]               io_address,
   output logic [31:0]               io_write_data,
   input  logic [31:0]               io_read_data
);

   localparam int CW = $clog2(WAIT_STATES + 2);
   localparam logic [CW-1:0] WS_LAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   bus_state_t state, state_next;

   logic        request, req_error, io_hit, misaligned;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wdata;
   logic        write_q;
   logic [CW-1:0] hold_cnt;

   store_lane_formatter u_fmt (
      .size        (cpu_data_size),
      .offset      (cpu_address[1:0]),
      .data        (cpu_data_out),
      .byte_enable (fmt_be),
      .write_data  (fmt_wdata),
      .misaligned  (misaligned)
   );

   assign request   = cpu_read | cpu_write;
   assign req_error = (cpu_read & cpu_write) | (cpu_data_size == 2'd3) | misaligned;
   assign io_hit    = (cpu_address[31:16] == IO_BASE[31:16]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      cpu_stall   = 1'b0;
      mem_request = 1'b0;
      io_select   = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               cpu_stall = 1'b1;
               if (req_error)   state_next = DONE;
               else if (io_hit) state_next = IO_ACCESS;
               else             state_next = RAM_WAIT;
            end
         end
         RAM_WAIT: begin
            cpu_stall   = 1'b1;
            mem_request = 1'b1;
            if (mem_ready) state_next = (WAIT_STATES == 0) ? DONE : RAM_HOLD;
         end
         RAM_HOLD: begin
            cpu_stall = 1'b1;
            if (hold_cnt == WS_LAST) state_next = DONE;
         end
         IO_ACCESS: begin
            cpu_stall  = 1'b1;
            io_select  = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            // Only rearm once the core has let go, so a held level is not re-issued.
            if (!request) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_write     = mem_request & write_q;
   assign io_write      = io_select & write_q;
   assign io_write_data = mem_write_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         write_q         <= 1'b0;
         mem_address     <= '0;
         io_address      <= '0;
         mem_byte_enable <= 4'b0000;
         mem_write_data  <= '0;
         cpu_data_in     <= '0;
         bus_error       <= 1'b0;
         hold_cnt        <= '0;
      end else begin
         hold_cnt <= (state == RAM_HOLD) ? hold_cnt + 1'b1 : '0;
         case (state)
            IDLE: begin
               if (request && req_error) begin
                  bus_error   <= 1'b1;
                  cpu_data_in <= '0;
               end else if (request) begin
                  write_q         <= cpu_write;
                  mem_address     <= cpu_address[RAM_ADDR_WIDTH+1:2];
                  io_address      <= cpu_address[15:0];
                  mem_byte_enable <= fmt_be;
                  mem_write_data  <= fmt_wdata;
               end
            end
            RAM_WAIT:  if (mem_ready && !write_q) cpu_data_in <= mem_read_data;
            IO_ACCESS: if (!write_q) cpu_data_in <= io_read_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench with a transaction scoreboard for memory_bus_controller.
module tb_memory_bus_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] cpu_address = '0;
   logic [31:0] cpu_data_out = '0;
   logic [1:0]  cpu_data_size = '0;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [31:0] cpu_data_in;
   logic        cpu_stall;
   logic        bus_error;
   logic        mem_request;
   logic        mem_write;
   logic [11:0] mem_address;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data = '0;
   logic        mem_ready = 1'b0;
   logic        io_select;
   logic        io_write;
   logic [15:0] io_address;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data = '0;

   memory_bus_controller #(
      .RAM_ADDR_WIDTH (12),
      .IO_BASE        (32'hFFFF_0000),
      .WAIT_STATES    (1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cpu_address     (cpu_address),
      .cpu_data_out    (cpu_data_out),
      .cpu_data_size   (cpu_data_size),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_data_in     (cpu_data_in),
      .cpu_stall       (cpu_stall),
      .bus_error       (bus_error),
      .mem_request     (mem_request),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_byte_enable (mem_byte_enable),
      .mem_write_data  (mem_write_data),
      .mem_read_data   (mem_read_data),
      .mem_ready       (mem_ready),
      .io_select       (io_select),
      .io_write        (io_write),
      .io_address      (io_address),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      logic        is_io;
      logic        wr;
      logic [15:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb_q[$];
   int compared = 0;
   int mismatched = 0;
   int ready_delay = 0;
   int wait_cnt = 0;
   int req_pulses = 0;
   int io_pulses = 0;
   logic req_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_txn(input logic is_io, input logic wr, input logic [15:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
      exp_t e;
      e.is_io = is_io; e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata;
      sb_q.push_back(e);
   endtask

   // RAM responder and scoreboard: ready after ready_delay request cycles.
   always @(negedge clock) begin
      exp_t e;
      if (!mem_request) begin
         wait_cnt  = 0;
         mem_ready = 1'b0;
      end else begin
         if (!req_prev) req_pulses++;
         if (wait_cnt == ready_delay) begin
            mem_ready = 1'b1;
            if (sb_q.size() == 0) begin
               check("ram_unexpected", 32'(mem_request), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("ram_is_io", 32'(e.is_io), 32'd0);
               check("ram_addr", 32'(mem_address), 32'(e.addr));
               check("ram_be", 32'(mem_byte_enable), 32'(e.be));
               check("ram_write", 32'(mem_write), 32'(e.wr));
               if (e.wr) check("ram_wdata", mem_write_data, e.wdata);
            end
         end else begin
            mem_ready = 1'b0;
         end
         wait_cnt++;
      end
      req_prev = mem_request;
   end

   always @(negedge clock) begin
      exp_t e;
      if (io_select) begin
         io_pulses++;
         check("io_no_mem_req", 32'(mem_request), 32'd0);
         if (sb_q.size() == 0) begin
            check("io_unexpected", 32'(io_select), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("io_is_io", 32'(e.is_io), 32'd1);
            check("io_addr", 32'(io_address), 32'(e.addr));
            check("io_write", 32'(io_write), 32'(e.wr));
            if (e.wr) check("io_wdata", io_write_data, e.wdata);
         end
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] data, input int delay,
                         output int stall_cyc);
      @(posedge clock); #1;
      ready_delay   = delay;
      cpu_read      = rd;
      cpu_write     = wr;
      cpu_address   = addr;
      cpu_data_size = size;
      cpu_data_out  = data;
      stall_cyc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (!cpu_stall) break;
         stall_cyc++;
      end
   endtask

   task automatic release_req();
      @(posedge clock); #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      @(posedge clock); #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int p0;
      int stall_hi;
      int req_hi;

      // Reset state
      @(negedge clock);
      check("rst_mem_request", 32'(mem_request), 32'd0);
      check("rst_io_select", 32'(io_select), 32'd0);
      check("rst_bus_error", 32'(bus_error), 32'd0);
      check("rst_cpu_data_in", cpu_data_in, 32'd0);
      check("rst_byte_enable", 32'(mem_byte_enable), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
      @(posedge clock); #1 reset = 1'b1;

      // Store byte to RAM, ready immediately
      expect_txn(1'b0, 1'b1, 16'h041, 4'b0010, 32'hDDDD_DDDD);
      access(1'b0, 1'b1, 32'h0000_0105, 2'd0, 32'hAABB_CCDD, 0, st);
      check("sb_stall", 32'(st), 32'd3);
      release_req();

      // Load word, ready after 3 cycles
      mem_read_data = 32'h1234_5678;
      expect_txn(1'b0, 1'b0, 16'h004, 4'b1111, 32'h0);
      access(1'b1, 1'b0, 32'h0000_0010, 2'd2, 32'h0, 3, st);
      check("lw_stall", 32'(st), 32'd6);
      check("lw_data", cpu_data_in, 32'h1234_5678);
      release_req();

      // IO half store
      p0 = req_pulses;
      expect_txn(1'b1, 1'b1, 16'h0022, 4'b1100, 32'h3344_3344);
      access(1'b0, 1'b1, 32'hFFFF_0022, 2'd1, 32'h1122_3344, 0, st);
      check("io_sh_stall", 32'(st), 32'd2);
      check("io_sh_no_ram", 32'(req_pulses - p0), 32'd0);
      release_req();

      // IO word load
      io_read_data = 32'hCAFE_F00D;
      expect_txn(1'b1, 1'b0, 16'h0100, 4'b1111, 32'h0);
      access(1'b1, 1'b0, 32'hFFFF_0100, 2'd2, 32'h0, 0, st);
      check("io_lw_stall", 32'(st), 32'd2);
      check("io_lw_data", cpu_data_in, 32'hCAFE_F00D);
      release_req();

      // Misaligned word load
      p0 = req_pulses;
      access(1'b1, 1'b0, 32'h0000_0002, 2'd2, 32'h0, 0, st);
      check("mis_w_stall", 32'(st), 32'd1);
      check("mis_w_error", 32'(bus_error), 32'd1);
      check("mis_w_data", cpu_data_in, 32'd0);
      release_req();

      // Misaligned half load, then reserved size
      access(1'b1, 1'b0, 32'h0000_0003, 2'd1, 32'h0, 0, st);
      check("mis_h_stall", 32'(st), 32'd1);
      release_req();
      access(1'b0, 1'b1, 32'h0000_0000, 2'd3, 32'h0, 0, st);
      check("size3_stall", 32'(st), 32'd1);
      release_req();
      check("err_no_ram", 32'(req_pulses - p0), 32'd0);
      check("err_no_io", 32'(io_pulses), 32'd2);

      // Byte load on an aliased address, then hold read for 10 cycles
      p0 = req_pulses;
      mem_read_data = 32'h5566_7788;
      expect_txn(1'b0, 1'b0, 16'h000, 4'b1000, 32'h0);
      access(1'b1, 1'b0, 32'h0000_4003, 2'd0, 32'h0, 1, st);
      check("hold_stall", 32'(st), 32'd4);
      check("hold_data", cpu_data_in, 32'h5566_7788);
      stall_hi = 0;
      req_hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (cpu_stall) stall_hi++;
         if (mem_request) req_hi++;
      end
      check("hold_no_stall", 32'(stall_hi), 32'd0);
      check("hold_no_req", 32'(req_hi), 32'd0);
      check("hold_one_pulse", 32'(req_pulses - p0), 32'd1);
      check("err_sticky", 32'(bus_error), 32'd1);
      release_req();
      expect_txn(1'b0, 1'b1, 16'h002, 4'b1111, 32'hDEAD_BEEF);
      access(1'b0, 1'b1, 32'h0000_0008, 2'd2, 32'hDEAD_BEEF, 2, st);
      check("after_hold_stall", 32'(st), 32'd5);
      check("after_hold_pulse", 32'(req_pulses - p0), 32'd2);
      release_req();

      // Reset while in RAM_WAIT
      expect_txn(1'b0, 1'b0, 16'h008, 4'b1111, 32'h0);
      @(posedge clock); #1;
      ready_delay = 100;
      cpu_read = 1'b1; cpu_address = 32'h0000_0020; cpu_data_size = 2'd2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (mem_request) break;
      end
      check("rw_entered", 32'(mem_request), 32'd1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("rw_rst_req", 32'(mem_request), 32'd0);
      check("rw_rst_error", 32'(bus_error), 32'd0);
      check("rw_rst_be", 32'(mem_byte_enable), 32'd0);
      check("rw_rst_data", cpu_data_in, 32'd0);
      sb_q.delete(0);
      cpu_read = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      check("rw_rst_idle_stall", 32'(cpu_stall), 32'd0);
      expect_txn(1'b0, 1'b1, 16'h00C, 4'b0001, 32'hA5A5_A5A5);
      access(1'b0, 1'b1, 32'h0000_0030, 2'd0, 32'h0000_00A5, 0, st);
      check("post_rst_stall", 32'(st), 32'd3);
      check("post_rst_error", 32'(bus_error), 32'd0);
      release_req();

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
